hdlc_tx_frame_arbiter: RTL

Shares the single HDLC transmitter between NUM_SRC byte-stream frame sources (command, telemetry, housekeeping, ...).
- Grants one whole frame at a time, round-robin.
- Forwards the granted frame unchanged to the hdlc_tx stream input.
- Enforces a minimum idle gap between frames.
- Truncates and drains any frame longer than MAX_LEN bytes.
- Sits between the source FIFOs and hdlc_tx inside the RS422 top.

---
 rtl/hdlc_ctrl_pkg.sv | 21 ++
 rtl/hdlc_tx_frame_arbiter_if.sv | 19 +
 rtl/hdlc_tx_frame_arbiter_rr.sv | 29 ++
 rtl/hdlc_tx_frame_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/hdlc_ctrl_pkg.sv
// Shared types and constants for the HDLC transmit control blocks.
package hdlc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_MAX_LEN    = 1024;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/hdlc_tx_frame_arbiter_if.sv
// Byte-stream bundle between the source FIFOs, the frame arbiter and hdlc_tx.
interface hdlc_tx_frame_arbiter_if #(parameter int NUM_SRC = 4);

    logic [NUM_SRC-1:0]      s_tvalid;
    logic [NUM_SRC-1:0]      s_tready;
    logic [NUM_SRC-1:0]      s_tlast;
    logic [NUM_SRC-1:0][7:0] s_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;
    logic [7:0]              m_tdata;

    // master: the arbiter itself; slave: the surrounding sources and sink
    modport master (input  s_tvalid, s_tlast, s_tdata, m_tready,
                    output s_tready, m_tvalid, m_tlast, m_tdata);
    modport slave  (output s_tvalid, s_tlast, s_tdata, m_tready,
                    input  s_tready, m_tvalid, m_tlast, m_tdata);

endinterface

// File: rtl/hdlc_tx_frame_arbiter_rr.sv
// Combinational round-robin pick: first request found after the last grant.
module hdlc_rr_arbiter
    import hdlc_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
)(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_grant,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(i_last) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdlc_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of hdlc_tx: passes one frame,
// truncates/drains overlong frames, then holds an idle gap before re-arbitrating.
module hdlc_tx_frame_arbiter
    import hdlc_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    localparam int IW        = clog2(NUM_SRC)
)(
    input  logic                     clk,
    input  logic                     rst,
    hdlc_tx_frame_arbiter_if.master  bus,
    output logic [IW-1:0]            grant_id,
    output logic                     busy,
    output logic                     overlen_err
);

    localparam int CW = clog2(MAX_LEN + 1);
    localparam int GW = (clog2(GAP_CYCLES) < 1) ? 1 : clog2(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t        ST_END   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t        r_state, w_nstate;
    logic [IW-1:0] r_grant, r_last, w_pick;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_busy, r_ovf;
    logic          w_any, w_sv, w_sl, w_hs, w_at_max;

    hdlc_rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
        .i_req   (bus.s_tvalid),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    assign w_sv     = bus.s_tvalid[r_grant];
    assign w_sl     = bus.s_tlast[r_grant];
    assign w_at_max = (r_cnt == CNT_LAST);

    always_comb begin
        w_nstate     = r_state;
        w_hs         = 1'b0;
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tdata  = '0;
        case (r_state)
            ST_IDLE: if (w_any) w_nstate = ST_PASS;
            ST_PASS: begin
                bus.m_tvalid          = w_sv;
                bus.m_tdata           = bus.s_tdata[r_grant];
                // forced tlast closes an overlong frame cleanly for hdlc_tx
                bus.m_tlast           = w_sl | w_at_max;
                bus.s_tready[r_grant] = bus.m_tready;
                w_hs                  = w_sv & bus.m_tready;
                if (w_hs && w_sl)          w_nstate = ST_END;
                else if (w_hs && w_at_max) w_nstate = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.s_tready[r_grant] = 1'b1;
                if (w_sv && w_sl) w_nstate = ST_END;
            end
            ST_GAP:  if (r_gap == '0) w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_busy  <= (w_nstate != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_last  <= IW'(NUM_SRC - 1);
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
            end
            if (w_hs) begin
                r_cnt <= (w_sl || w_at_max) ? '0 : r_cnt + 1'b1;
                if (!w_sl && w_at_max) r_ovf <= 1'b1;
            end
            if (w_nstate == ST_GAP && r_state != ST_GAP) r_gap <= GAP_LOAD;
            else if (r_state == ST_GAP)                  r_gap <= r_gap - 1'b1;
        end
    end

    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign overlen_err = r_ovf;

endmodule
